// File: rtl/tausworthe_histogram.sv
// Histogram collector for tausworthe generator output: bins a fixed-length run of
// samples by their top bits into saturating counters, then streams the bins out.
module tausworthe_histogram #(
  parameter int BIN_BITS  = 3,
  parameter int CNT_W     = 16,
  parameter int N_SAMPLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_val,
  input  logic [31:0]         in_data,
  input  logic                out_rdy,
  output logic                out_val,
  output logic [BIN_BITS-1:0] out_bin,
  output logic [CNT_W-1:0]    out_count,
  output logic                busy,
  output logic                done
);

  localparam int NBINS  = 1 << BIN_BITS;
  localparam int SCNT_W = $clog2(N_SAMPLES + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DUMP    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [SCNT_W-1:0]   LAST_SAMPLE = SCNT_W'(N_SAMPLES - 1);
  localparam logic [BIN_BITS-1:0] LAST_BIN    = BIN_BITS'(NBINS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  logic [1:0]          state_r;
  logic [SCNT_W-1:0]   scnt_r;
  logic [BIN_BITS-1:0] ptr_r;
  logic [BIN_BITS-1:0] ptr_nxt_s;
  logic [CNT_W-1:0]    bin_r     [NBINS];
  logic [CNT_W-1:0]    bin_nxt_s [NBINS];
  logic [BIN_BITS-1:0] idx_s;
  logic                hit_s;
  logic                out_val_r;
  logic [BIN_BITS-1:0] out_bin_r;
  logic [CNT_W-1:0]    out_count_r;
  logic                busy_r;
  logic                done_r;
  logic                unused_data_s;

  assign idx_s         = in_data[31 -: BIN_BITS];
  assign unused_data_s = ^in_data[31-BIN_BITS:0];
  assign hit_s         = (state_r == S_COLLECT) && in_val;
  assign ptr_nxt_s     = ptr_r + BIN_BITS'(1);

  assign out_val   = out_val_r;
  assign out_bin   = out_bin_r;
  assign out_count = out_count_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Next bin values including the sample accepted this cycle
  always_comb begin
    for (int i = 0; i < NBINS; i++) begin
      if (hit_s && (idx_s == BIN_BITS'(i))) begin
        bin_nxt_s[i] = sat_inc(bin_r[i]);
      end else begin
        bin_nxt_s[i] = bin_r[i];
      end
    end
  end

  // Bin storage: cleared on a new run, otherwise follows the next-value array
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NBINS; i++) begin
        bin_r[i] <= {CNT_W{1'b0}};
      end
    end else if ((state_r == S_IDLE) && start) begin
      for (int i = 0; i < NBINS; i++) begin
        bin_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NBINS; i++) begin
        bin_r[i] <= bin_nxt_s[i];
      end
    end
  end

  // Run control FSM and registered output word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      scnt_r      <= {SCNT_W{1'b0}};
      ptr_r       <= {BIN_BITS{1'b0}};
      out_val_r   <= 1'b0;
      out_bin_r   <= {BIN_BITS{1'b0}};
      out_count_r <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r <= S_COLLECT;
            scnt_r  <= {SCNT_W{1'b0}};
            busy_r  <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (in_val) begin
            scnt_r <= scnt_r + SCNT_W'(1);
            if (scnt_r == LAST_SAMPLE) begin
              // First word forwards bin 0 including the final sample
              state_r     <= S_DUMP;
              ptr_r       <= {BIN_BITS{1'b0}};
              out_val_r   <= 1'b1;
              out_bin_r   <= {BIN_BITS{1'b0}};
              out_count_r <= bin_nxt_s[0];
            end
          end
        end
        S_DUMP: begin
          if (out_rdy) begin
            if (ptr_r == LAST_BIN) begin
              state_r   <= S_DONE;
              out_val_r <= 1'b0;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
            end else begin
              ptr_r       <= ptr_nxt_s;
              out_bin_r   <= ptr_nxt_s;
              out_count_r <= bin_r[ptr_nxt_s];
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r   <= S_IDLE;
          out_val_r <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tausworthe_histogram.sv
// Randomized self-checking bench for tausworthe_histogram: a default-sized
// instance and a small saturating instance, checked against an array-count model.
module tb_tausworthe_histogram;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start_v;
  logic        in_val;
  logic [31:0] in_data;
  logic        out_rdy;

  logic        val_a, busy_a, done_a;
  logic [2:0]  bin_a;
  logic [15:0] count_a;
  logic        val_b, busy_b, done_b;
  logic [2:0]  bin_b;
  logic [3:0]  count_b;

  int          sel;
  logic        m_val, m_busy, m_done;
  logic [2:0]  m_bin;
  logic [15:0] m_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tausworthe_histogram dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_val(in_val), .in_data(in_data),
    .out_rdy(out_rdy), .out_val(val_a), .out_bin(bin_a), .out_count(count_a),
    .busy(busy_a), .done(done_a)
  );

  tausworthe_histogram #(.BIN_BITS(3), .CNT_W(4), .N_SAMPLES(20)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_val(in_val), .in_data(in_data),
    .out_rdy(out_rdy), .out_val(val_b), .out_bin(bin_b), .out_count(count_b),
    .busy(busy_b), .done(done_b)
  );

  assign m_val   = (sel == 1) ? val_b  : val_a;
  assign m_busy  = (sel == 1) ? busy_b : busy_a;
  assign m_done  = (sel == 1) ? done_b : done_a;
  assign m_bin   = (sel == 1) ? bin_b  : bin_a;
  assign m_count = (sel == 1) ? {12'd0, count_b} : count_a;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int n_of(input int s);
    return (s == 1) ? 20 : 1024;
  endfunction

  function automatic int max_of(input int s);
    return (s == 1) ? 15 : 65535;
  endfunction

  // mode 0: uniform random, 1: fixed value, 2: random confined to bins 0/1
  task automatic run_test(input int s, input int gap_pct, input int stall_max,
                          input int mode, input logic [31:0] fixval);
    int hist[8];
    int exp_cnt[8];
    int acc, sum_obs, sum_exp, stalls;
    logic [31:0] d;
    sel = s;
    for (int b = 0; b < 8; b++) hist[b] = 0;
    @(negedge clk);
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v = 2'b00;
    check_val("busy_after_start", {31'd0, m_busy}, 32'd1);
    check_val("no_val_in_collect", {31'd0, m_val}, 32'd0);
    acc = 0;
    while (acc < n_of(s)) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        in_val  = 1'b0;
        in_data = $urandom;
      end else begin
        case (mode)
          0:       d = $urandom;
          1:       d = fixval;
          default: d = {2'b00, 1'($urandom_range(0, 1)), 29'($urandom)};
        endcase
        in_val  = 1'b1;
        in_data = d;
        hist[d[31:29]]++;
        acc++;
      end
      @(negedge clk);
    end
    sum_exp = 0;
    for (int b = 0; b < 8; b++) begin
      exp_cnt[b] = (hist[b] > max_of(s)) ? max_of(s) : hist[b];
      sum_exp += exp_cnt[b];
    end
    sum_obs = 0;
    for (int b = 0; b < 8; b++) begin
      stalls = $urandom_range(0, stall_max);
      for (int k = 0; k < stalls; k++) begin
        check_val("stall_val", {31'd0, m_val}, 32'd1);
        check_val("stall_bin", {29'd0, m_bin}, b);
        check_val("stall_count", {16'd0, m_count}, exp_cnt[b]);
        out_rdy = 1'b0;
        in_val  = 1'($urandom_range(0, 1));
        in_data = $urandom;
        @(negedge clk);
      end
      check_val("word_val", {31'd0, m_val}, 32'd1);
      check_val("word_bin", {29'd0, m_bin}, b);
      check_val("word_count", {16'd0, m_count}, exp_cnt[b]);
      sum_obs += int'(m_count);
      out_rdy = 1'b1;
      in_val  = 1'($urandom_range(0, 1));
      in_data = $urandom;
      @(negedge clk);
    end
    check_val("done_pulse", {31'd0, m_done}, 32'd1);
    check_val("busy_in_done", {31'd0, m_busy}, 32'd0);
    check_val("val_in_done", {31'd0, m_val}, 32'd0);
    out_rdy    = 1'b0;
    in_val     = 1'b0;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v = 2'b00;
    check_val("done_one_cycle", {31'd0, m_done}, 32'd0);
    check_val("start_in_done_ignored", {31'd0, m_busy}, 32'd0);
    check_val("count_sum", sum_obs, sum_exp);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_val"}, {31'd0, m_val}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, m_busy}, 32'd0);
    check_val({tag, "_done"}, {31'd0, m_done}, 32'd0);
    check_val({tag, "_count"}, {16'd0, m_count}, 32'd0);
    check_val({tag, "_bin"}, {29'd0, m_bin}, 32'd0);
  endtask

  // Starts a run, feeds n_pre samples, then resets asynchronously between edges
  task automatic abort_run(input int s, input int n_pre);
    sel = s;
    @(negedge clk);
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v = 2'b00;
    for (int k = 0; k < n_pre; k++) begin
      in_val  = 1'b1;
      in_data = $urandom;
      @(negedge clk);
    end
    in_val = 1'b0;
    if (n_pre >= n_of(s)) begin
      check_val("val_before_abort", {31'd0, m_val}, 32'd1);
    end else begin
      check_val("busy_before_abort", {31'd0, m_busy}, 32'd1);
    end
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("abort");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b1;
    start_v = 2'b00;
    in_val  = 1'b0;
    in_data = 32'd0;
    out_rdy = 1'b0;
    sel     = 0;
    #3;
    rst = 1'b0;
    #1;
    sel = 0;
    check_reset_state("reset_a");
    sel = 1;
    check_reset_state("reset_b");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_test(0, 0, 0, 1, 32'hE000_0000);
    run_test(0, 50, 3, 0, 32'd0);
    run_test(1, 0, 0, 1, 32'h4000_0000);
    repeat (4) run_test(1, 30, 3, 2, 32'd0);
    run_test(1, 20, 2, 0, 32'd0);
    abort_run(0, 5);
    run_test(0, 0, 0, 1, 32'h2000_0000);
    abort_run(1, 20);
    run_test(1, 10, 1, 0, 32'd0);
    run_test(0, 0, 0, 0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
